fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Shares the single frame-buffer write port (we/waddr/wdata into the VGA block's video RAM) among three drawing requesters: board grid, stone renderer and cursor overlay.
- Round-robin arbitration, one write per clock.
- Includes a clear sequencer that fills the whole frame buffer with a background colour after reset or on command.
- Sits between the game drawing logic and the VGA frame-buffer write port.

Parameters:
- DW, 15, frame-buffer address width.
- CW, 12, pixel colour width (4:4:4 RGB).
- FB_DEPTH, 30000, number of valid frame-buffer words (addresses 0..FB_DEPTH-1).
- CLEAR_ON_RESET, 1, when 1 a clear starts automatically after reset release.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rstn  in  1  reset, asynchronous, active-low.
- clear_start  in  1  one-cycle pulse: start full-buffer clear.
- bg_color  in  CW  clear colour, latched when a clear starts.
- req0, req1, req2  in  1 each  write request, held until granted.
- addr0, addr1, addr2  in  DW each  requester write address.
- data0, data1, data2  in  CW each  requester write data.
- gnt0, gnt1, gnt2  out  1 each  combinational grant; transfer occurs at the edge where req_i & gnt_i.
- we  out  1  registered frame-buffer write enable.
- waddr  out  DW  registered write address.
- wdata  out  CW  registered write data.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- oor_flag  out  1  sticky: a granted request had addr >= FB_DEPTH.

Behaviour:
- Reset values:
  - we=0, waddr=0, wdata=0, clear_done=0, oor_flag=0.
  - clear_busy = CLEAR_ON_RESET.
  - clear counter=0.
  - round-robin pointer last=2, so requester 0 has top priority first.
- States: IDLE (arbitrating) and CLEAR.
  - IDLE -> CLEAR on clear_start=1.
  - CLEAR -> IDLE after the write of address FB_DEPTH-1.
- Grants (combinational):
  - All gnt=0 when clear_busy=1, or when clear_start=1 in IDLE (clear wins over simultaneous requests).
  - Otherwise at most one gnt_i=1: the first asserted req in order last+1, last+2, last+3 (mod 3).
- Transfer rules:
  - At an edge with req_i & gnt_i: last<=i; next cycle we=1, waddr=addr_i, wdata=data_i.
  - Latency from accepting edge to write visible on the port is one cycle.
  - Requesters may keep req high for back-to-back writes, but are rotated against other active requesters.
- Out-of-range requests:
  - A granted request with addr_i >= FB_DEPTH is consumed (gnt given, last updated).
  - That request produces we=0, and oor_flag<=1 until reset.
- Idle cycles: with no transfer and not clearing, we<=0 and waddr/wdata hold their previous values.
- Clear sequence:
  - At edge E where clear_start is sampled in IDLE: clear_busy<=1, counter<=0, colour latch<=bg_color.
  - Each subsequent edge in CLEAR: we<=1, waddr<=counter, wdata<=latched colour, counter++. This is one write per cycle for addresses 0..FB_DEPTH-1 in order.
  - At the edge registering address FB_DEPTH-1 (edge E+FB_DEPTH): clear_busy<=0 and clear_done<=1 for exactly one cycle.
  - Grants resume combinationally in the following cycle.
- Auto-clear after reset: with CLEAR_ON_RESET=1 the clear begins at the first edge after rstn deasserts, using bg_color sampled at that edge, and otherwise behaves as above.
- Ignored / aborted cases:
  - clear_start while clear_busy=1 is ignored; the sweep is not restarted.
  - Reset asserted mid-clear or mid-write aborts immediately to the reset values above. With CLEAR_ON_RESET=1 the clear restarts from address 0.
- Counter width: DW bits; the counter never exceeds FB_DEPTH-1, so there is no wrap-around.

Test Plan:
1. FB_DEPTH=16, CLEAR_ON_RESET=1, bg_color=12'hDA6, release rstn → 16 consecutive cycles with we=1, waddr=0..15, wdata=12'hDA6; clear_done pulses once with the last write; clear_busy low afterwards; all gnt=0 throughout the clear.
2. After the clear, hold req0, req1 and req2 continuously with distinct addr/data → grants rotate 0,1,2,0,1,2; each write appears one cycle after its grant with the matching addr/data; we stays high every cycle.
3. Only req1 asserted, addr1=5, data1=12'hF00, held one cycle → gnt1=1 that cycle; next cycle we=1, waddr=5, wdata=12'hF00; then we=0.
4. clear_start and req0 asserted in the same cycle → gnt0=0; clear proceeds over addresses 0..15; req0 still held is granted in the first cycle after clear_done.
5. req2 with addr2=20 (FB_DEPTH=16) → gnt2=1, we stays 0, oor_flag=1 and remains 1 until reset.
6. Assert rstn=0 during a clear at address 7 → outputs return to reset values immediately; after release the clear restarts from waddr=0; a clear_start pulsed mid-clear is ignored (the sweep still completes in 16 writes).

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: round-robin among three drawing requesters,
// plus a full-buffer clear sweep run after reset or on command.
module fb_write_arbiter #(
    parameter int DW             = 15,
    parameter int CW             = 12,
    parameter int FB_DEPTH       = 30000,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear_start,
    input  logic [CW-1:0] bg_color,
    input  logic          req0,
    input  logic          req1,
    input  logic          req2,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] addr2,
    input  logic [CW-1:0] data0,
    input  logic [CW-1:0] data1,
    input  logic [CW-1:0] data2,
    output logic          gnt0,
    output logic          gnt1,
    output logic          gnt2,
    output logic          we,
    output logic [DW-1:0] waddr,
    output logic [CW-1:0] wdata,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          oor_flag
);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [DW-1:0] LAST_ADDR = DW'(FB_DEPTH - 1);

    state_t        r_state, w_state_nxt;
    logic          r_arm;
    logic [DW-1:0] r_cnt;
    logic [CW-1:0] r_color;
    logic [1:0]    r_last;
    logic          r_we, r_done, r_oor;
    logic [DW-1:0] r_waddr;
    logic [CW-1:0] r_wdata;

    logic [2:0]    w_req, w_gnt;
    logic [1:0]    w_ord [3];
    logic [1:0]    w_sel;
    logic          w_xfer, w_oor;
    logic [DW-1:0] w_addr;
    logic [CW-1:0] w_data;

    assign w_req = {req2, req1, req0};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_start) w_state_nxt = S_CLEAR;
            S_CLEAR: if (!r_arm && r_cnt == LAST_ADDR) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Search order starts just after the last winner.
    always_comb begin
        case (r_last)
            2'd0:    begin w_ord[0] = 2'd1; w_ord[1] = 2'd2; w_ord[2] = 2'd0; end
            2'd1:    begin w_ord[0] = 2'd2; w_ord[1] = 2'd0; w_ord[2] = 2'd1; end
            default: begin w_ord[0] = 2'd0; w_ord[1] = 2'd1; w_ord[2] = 2'd2; end
        endcase
    end

    always_comb begin
        w_gnt  = 3'b000;
        w_sel  = 2'd0;
        w_xfer = 1'b0;
        if (r_state == S_IDLE && !clear_start) begin
            for (int k = 0; k < 3; k++) begin
                if (!w_xfer && w_req[w_ord[k]]) begin
                    w_gnt[w_ord[k]] = 1'b1;
                    w_sel           = w_ord[k];
                    w_xfer          = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (w_sel)
            2'd1:    begin w_addr = addr1; w_data = data1; end
            2'd2:    begin w_addr = addr2; w_data = data2; end
            default: begin w_addr = addr0; w_data = data0; end
        endcase
    end

    assign w_oor = (w_addr > LAST_ADDR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RST_STATE;
            r_arm   <= (CLEAR_ON_RESET != 0);
            r_cnt   <= '0;
            r_color <= '0;
            r_last  <= 2'd2;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            if (r_state == S_IDLE) begin
                if (clear_start) begin
                    r_cnt   <= '0;
                    r_color <= bg_color;
                end else if (w_xfer) begin
                    r_last <= w_sel;
                    if (w_oor) begin
                        r_oor <= 1'b1;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= w_addr;
                        r_wdata <= w_data;
                    end
                end
            end else if (r_arm) begin
                // Auto-clear after reset: this edge only captures the colour.
                r_arm   <= 1'b0;
                r_cnt   <= '0;
                r_color <= bg_color;
            end else begin
                r_we    <= 1'b1;
                r_waddr <= r_cnt;
                r_wdata <= r_color;
                if (r_cnt == LAST_ADDR) r_done <= 1'b1;
                else                    r_cnt  <= r_cnt + DW'(1);
            end
        end
    end

    assign gnt0       = w_gnt[0];
    assign gnt1       = w_gnt[1];
    assign gnt2       = w_gnt[2];
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign clear_busy = (r_state == S_CLEAR);
    assign clear_done = r_done;
    assign oor_flag   = r_oor;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: expected writes are queued as stimulus is driven
// and popped by a monitor whenever the write port fires.
module tb_fb_write_arbiter;

    localparam int DW = 15;
    localparam int CW = 12;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [CW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear_start;
    logic [CW-1:0] bg_color;
    logic          req0, req1, req2;
    logic [DW-1:0] addr0, addr1, addr2;
    logic [CW-1:0] data0, data1, data2;
    logic          gnt0, gnt1, gnt2;
    logic          we;
    logic [DW-1:0] waddr;
    logic [CW-1:0] wdata;
    logic          clear_busy, clear_done, oor_flag;
    logic [2:0]    gv;

    wr_t sb[$];
    wr_t mon_e;
    int  n_chk = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;

    assign gv = {gnt2, gnt1, gnt0};

    fb_write_arbiter #(.DW(DW), .CW(CW), .FB_DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rstn(rstn), .clear_start(clear_start), .bg_color(bg_color),
        .req0(req0), .req1(req1), .req2(req2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .clear_busy(clear_busy), .clear_done(clear_done), .oor_flag(oor_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && we) begin
            if (sb.size() == 0) begin
                chk("spurious_we", 32'(we), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(waddr), 32'(mon_e.a));
                chk("wr_data", 32'(wdata), 32'(mon_e.d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear(input logic [CW-1:0] c);
        for (int i = 0; i < DEPTH; i++) sb.push_back({DW'(i), c});
    endtask

    // Returns at the negedge where clear_done is seen (or after the bound).
    task automatic wait_done(input string tag, input int pulse_at, output int nwe);
        bit got;
        got = 1'b0;
        nwe = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (pulse_at >= 0) clear_start = (t == pulse_at);
            if (clear_busy) chk({tag, "_gnt_in_clear"}, 32'(gv), 32'd0);
            if (we) nwe++;
            if (clear_done) got = 1'b1;
        end
        clear_start = 1'b0;
        if (!got) chk({tag, "_done_timeout"}, 32'(clear_done), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    32'(we),         32'd0);
        chk({tag, "_waddr"}, 32'(waddr),      32'd0);
        chk({tag, "_wdata"}, 32'(wdata),      32'd0);
        chk({tag, "_done"},  32'(clear_done), 32'd0);
        chk({tag, "_oor"},   32'(oor_flag),   32'd0);
        chk({tag, "_busy"},  32'(clear_busy), 32'd1);
    endtask

    initial begin
        int  nwe;
        bit  hit;
        rstn = 1'b0; clear_start = 1'b0; bg_color = 12'hDA6;
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        data0 = '0; data1 = '0; data2 = '0;

        // 1: auto-clear after reset release
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        mon_en = 1'b1;
        push_clear(12'hDA6);
        step();
        rstn = 1'b1;
        wait_done("clr1", -1, nwe);
        chk("clr1_nwe", 32'(nwe), 32'd16);
        chk("clr1_last_addr", 32'(waddr), 32'(DEPTH - 1));
        step();
        @(negedge clk);
        chk("clr1_busy_after", 32'(clear_busy), 32'd0);
        chk("clr1_we_after", 32'(we), 32'd0);

        // 2: all three requesting -> strict rotation, back-to-back writes
        step();
        req0 = 1'b1; addr0 = 15'd3; data0 = 12'h111;
        req1 = 1'b1; addr1 = 15'd4; data1 = 12'h222;
        req2 = 1'b1; addr2 = 15'd6; data2 = 12'h333;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gv), 32'(3'b001 << (k % 3)));
            case (k % 3)
                0:       sb.push_back({addr0, data0});
                1:       sb.push_back({addr1, data1});
                default: sb.push_back({addr2, data2});
            endcase
            if (k > 0) chk("rr_we", 32'(we), 32'd1);
            step();
        end
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        @(negedge clk);
        chk("rr_we_last", 32'(we), 32'd1);

        // 3: single request, one-cycle write then idle
        step();
        req1 = 1'b1; addr1 = 15'd5; data1 = 12'hF00;
        @(negedge clk);
        chk("single_gnt", 32'(gv), 32'b010);
        sb.push_back({addr1, data1});
        step();
        req1 = 1'b0;
        @(negedge clk);
        chk("single_we", 32'(we), 32'd1);
        step();
        @(negedge clk);
        chk("single_we_off", 32'(we), 32'd0);
        chk("single_waddr_hold", 32'(waddr), 32'd5);

        // 4: clear_start beats a simultaneous request; request served after clear
        step();
        clear_start = 1'b1; bg_color = 12'h123;
        req0 = 1'b1; addr0 = 15'd9; data0 = 12'h0AB;
        @(negedge clk);
        chk("clr4_gnt_start", 32'(gv), 32'd0);
        push_clear(12'h123);
        step();
        clear_start = 1'b0;
        wait_done("clr4", -1, nwe);
        chk("clr4_nwe", 32'(nwe), 32'd16);
        chk("clr4_gnt_after", 32'(gv), 32'b001);
        sb.push_back({addr0, data0});
        step();
        req0 = 1'b0;
        @(negedge clk);
        chk("clr4_req_we", 32'(we), 32'd1);

        // 5: out-of-range address is consumed without a write
        step();
        req2 = 1'b1; addr2 = 15'd20; data2 = 12'h777;
        @(negedge clk);
        chk("oor_gnt", 32'(gv), 32'b100);
        step();
        req2 = 1'b0;
        @(negedge clk);
        chk("oor_we", 32'(we), 32'd0);
        chk("oor_flag", 32'(oor_flag), 32'd1);
        repeat (3) step();
        @(negedge clk);
        chk("oor_sticky", 32'(oor_flag), 32'd1);

        // 6: reset mid-clear restarts the sweep; clear_start during it ignored
        mon_en = 1'b0;
        step();
        clear_start = 1'b1; bg_color = 12'h5A5;
        step();
        clear_start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 40 && !hit; t++) begin
            @(negedge clk);
            if (we && waddr == 15'd7) hit = 1'b1;
        end
        chk("abort_reach7", 32'(hit), 32'd1);
        rstn = 1'b0;
        #1;
        chk_reset_vals("abort");
        chk("abort_gnt", 32'(gv), 32'd0);
        sb.delete();
        push_clear(12'h5A5);
        step();
        mon_en = 1'b1;
        rstn = 1'b1;
        wait_done("clr6", 5, nwe);
        chk("clr6_nwe", 32'(nwe), 32'd16);
        chk("clr6_oor_cleared", 32'(oor_flag), 32'd0);
        step();
        @(negedge clk);
        chk("clr6_busy_after", 32'(clear_busy), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
